dvp_pattern_tx: RTL and testbench
=================================

// Module: dvp_pattern_tx
// PURPOSE
//  Synthetic OV5640-style DVP transmitter: drives cam_vsync/cam_href/cam_data as the camera does,
//  RGB565 sent as 2 bytes per pixel. Feeds the ov5640 capture path (vip/ddr3_top/hdmi) in place of
//  a sensor, for bring-up and simulation. Runs in the pixel-clock domain it drives.
// PARAMETERS
//  H_PIXEL     1024  active pixels per line (multiple of 8)
//  V_PIXEL     768   active lines per frame
//  H_BLANK     256   clocks with href low after each active line
//  VSYNC_LINES 4     line periods with cam_vsync high
//  V_BP        16    blank line periods after vsync, before first active line
//  V_FP        8     blank line periods after last active line
// PORTS
//  clk          in   1   pixel/byte clock; all outputs change on rising edge
//  rst          in   1   asynchronous, active-high reset
//  enable       in   1   1 = generate frames continuously
//  pattern_sel  in   2   0 colour bars, 1 grey ramp, 2 checker, 3 solid
//  solid_color  in   16  RGB565 value for pattern 3
//  cam_vsync    out  1   frame sync, active high
//  cam_href     out  1   line valid, high across 2*H_PIXEL clocks per active line
//  cam_data     out  8   pixel byte: high byte {R[4:0],G[5:3]} first, then {G[2:0],B[4:0]}
//  frame_done   out  1   1-clock pulse on last clock of V_FP
//  frame_cnt    out  16  completed frames, wraps 16'hFFFF->0
// BEHAVIOUR
//  - Line period L = 2*H_PIXEL + H_BLANK clocks; every state is counted in line periods.
//  - FSM: IDLE -> VSYNC (VSYNC_LINES*L) -> VBP (V_BP*L) -> ACTIVE (V_PIXEL*L) -> VFP (V_FP*L).
//    In ACTIVE, href is high for clocks 0..2*H_PIXEL-1 of each line, low for H_BLANK.
//  - IDLE: enable sampled 1 -> VSYNC on next clock, cam_vsync=1 that clock.
//  - End of VFP: enable=1 -> VSYNC directly, no idle gap. enable=0 -> IDLE.
//  - Deasserting enable mid-frame never truncates; the current frame completes.
//  - pattern_sel and solid_color latched on IDLE->VSYNC and VFP->VSYNC transitions; constant per frame.
//  - Pixel x = 0..H_PIXEL-1 and line y = 0..V_PIXEL-1 are internal counters.
//  - Pattern 0: 8 bars, each H_PIXEL/8 wide. Counter-based, no divider.
//    Colours FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000.
//  - Pattern 1: {x[7:3],x[7:2],x[7:3]}. Pattern 2: (x[5]^y[5]) ? FFFF : 0000. Pattern 3: solid_color.
//  - cam_data=0 whenever href=0. href=0 whenever vsync=1.
//  - Registered outputs; pixel byte valid in the same clock as the href it accompanies.
//  - frame_cnt increments in the same clock as frame_done.
//  - Reset (any time, incl. mid-line): IDLE; cam_vsync=0, cam_href=0, cam_data=0, frame_done=0,
//    frame_cnt=0, latched pattern=0.
// CONFIGURATION
//  DVP_TX_FRAME_STAMP_EN defined: pixel (0,0) of each frame carries frame_cnt instead of the pattern
//   value, bytes frame_cnt[15:8] then [7:0], so capture-side frame drops/repeats are detectable.
//  Undefined: pixel (0,0) is the normal pattern value; no extra logic.
// TESTING  (H_PIXEL=16,V_PIXEL=4,H_BLANK=8,VSYNC_LINES=1,V_BP=1,V_FP=1: L=40, frame=280 clocks)
//  - rst high, enable=1 -> all outputs 0. rst low -> vsync rises 1 clock after first enable sample,
//    stays high 40 clocks.
//  - Pattern 0, one frame -> 4 href pulses of 32 clocks, 8 low between.
//    Bytes FF,FF,FF,FF,FF,E0,FF,E0,07,FF,... per line; frame_done at clock 280; frame_cnt=1.
//  - Pattern 2 with x[5]/y[5] at 0 for all pixels -> all bytes 00. Pattern 3, solid=A5C3 -> A5,C3 repeated.
//  - enable dropped at clock 100 -> frame finishes, frame_done pulses, then IDLE with vsync low.
//  - pattern_sel changed mid-frame -> current frame unchanged; new pattern from next frame.
//  - rst pulsed mid-href -> outputs 0 on the rst edge; restart produces a clean full frame.
//  - DVP_TX_FRAME_STAMP_EN: frame 3 first bytes 00,02, rest of the frame is the normal pattern.

Source files
------------

// File: rtl/dvp_pattern_tx.sv
// Synthetic OV5640-style DVP source: vsync/href/byte stream of RGB565 test patterns.
// Optional DVP_TX_FRAME_STAMP_EN: pixel (0,0) of each frame carries frame_cnt.
module dvp_pattern_tx #(
    parameter int H_PIXEL     = 1024,
    parameter int V_PIXEL     = 768,
    parameter int H_BLANK     = 256,
    parameter int VSYNC_LINES = 4,
    parameter int V_BP        = 16,
    parameter int V_FP        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int L  = 2 * H_PIXEL + H_BLANK;
    localparam int HW = $clog2(L);
    localparam int VW = $clog2(V_PIXEL + V_BP + V_FP + VSYNC_LINES + 1);
    localparam int BW = H_PIXEL / 8;
    localparam int PW = $clog2(BW) + 1;

    localparam logic [HW-1:0] H_LAST   = HW'(L - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(2 * H_PIXEL);
    localparam logic [VW-1:0] VS_LAST  = VW'(VSYNC_LINES - 1);
    localparam logic [VW-1:0] VBP_LAST = VW'(V_BP - 1);
    localparam logic [VW-1:0] ACT_LAST = VW'(V_PIXEL - 1);
    localparam logic [VW-1:0] VFP_LAST = VW'(V_FP - 1);
    localparam logic [PW-1:0] BAR_LAST = PW'(BW - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

    state_t          state, nxt_state;
    logic [HW-1:0]   h_cnt, nxt_h;
    logic [VW-1:0]   line_cnt, nxt_line;
    logic [2:0]      bar_idx, nxt_bar_idx;
    logic [PW-1:0]   bar_px, nxt_bar_px;
    logic [1:0]      pat_sel_q, nxt_pat_sel;
    logic [15:0]     solid_q, nxt_solid;
    logic            line_end, state_last;
    logic [4:0]      gx5;
    logic [5:0]      gx6;
    logic            chk_x, chk_y;
    logic [15:0]     pix;
    logic            nxt_vsync, nxt_href, nxt_done;
    logic [7:0]      nxt_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            h_cnt     <= '0;
            line_cnt  <= '0;
            bar_idx   <= '0;
            bar_px    <= '0;
            pat_sel_q <= '0;
            solid_q   <= '0;
        end else begin
            state     <= nxt_state;
            h_cnt     <= nxt_h;
            line_cnt  <= nxt_line;
            bar_idx   <= nxt_bar_idx;
            bar_px    <= nxt_bar_px;
            pat_sel_q <= nxt_pat_sel;
            solid_q   <= nxt_solid;
        end
    end

    // Outputs are decoded from the next-state values and registered, so they
    // describe the clock the FSM is entering with no extra pipeline delay.
    always_comb begin
        nxt_state   = state;
        nxt_h       = h_cnt;
        nxt_line    = line_cnt;
        nxt_pat_sel = pat_sel_q;
        nxt_solid   = solid_q;
        nxt_bar_idx = bar_idx;
        nxt_bar_px  = bar_px;
        state_last  = 1'b0;
        line_end    = (h_cnt == H_LAST);

        case (state)
            VSYNC:   state_last = (line_cnt == VS_LAST);
            VBP:     state_last = (line_cnt == VBP_LAST);
            ACTIVE:  state_last = (line_cnt == ACT_LAST);
            VFP:     state_last = (line_cnt == VFP_LAST);
            default: state_last = 1'b0;
        endcase

        if (state == IDLE) begin
            nxt_h    = '0;
            nxt_line = '0;
            if (enable) begin
                nxt_state   = VSYNC;
                nxt_pat_sel = pattern_sel;
                nxt_solid   = solid_color;
            end
        end else begin
            nxt_h = line_end ? '0 : h_cnt + 1'b1;
            if (line_end) begin
                nxt_line = state_last ? '0 : line_cnt + 1'b1;
                if (state_last) begin
                    case (state)
                        VSYNC:  nxt_state = VBP;
                        VBP:    nxt_state = ACTIVE;
                        ACTIVE: nxt_state = VFP;
                        default: begin
                            if (enable) begin
                                nxt_state   = VSYNC;
                                nxt_pat_sel = pattern_sel;
                                nxt_solid   = solid_color;
                            end else begin
                                nxt_state = IDLE;
                            end
                        end
                    endcase
                end
            end
        end

        // Bar position tracked by counters; advances on the first byte of each pixel.
        if (nxt_h == '0) begin
            nxt_bar_idx = '0;
            nxt_bar_px  = '0;
        end else if (!nxt_h[0]) begin
            if (bar_px == BAR_LAST) begin
                nxt_bar_px  = '0;
                nxt_bar_idx = bar_idx + 1'b1;
            end else begin
                nxt_bar_px = bar_px + 1'b1;
            end
        end

        gx5   = 5'(nxt_h >> 4);
        gx6   = 6'(nxt_h >> 3);
        chk_x = 1'(nxt_h >> 6);
        chk_y = 1'(nxt_line >> 5);

        case (nxt_pat_sel)
            2'd0: begin
                case (nxt_bar_idx)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd1:    pix = {gx5, gx6, gx5};
            2'd2:    pix = (chk_x ^ chk_y) ? 16'hFFFF : 16'h0000;
            default: pix = nxt_solid;
        endcase

`ifdef DVP_TX_FRAME_STAMP_EN
        if ((nxt_h < HW'(2)) && (nxt_line == '0))
            pix = frame_cnt;
`endif

        nxt_vsync = (nxt_state == VSYNC);
        nxt_href  = (nxt_state == ACTIVE) && (nxt_h < H_ACT);
        nxt_data  = nxt_href ? (nxt_h[0] ? pix[7:0] : pix[15:8]) : '0;
        nxt_done  = (nxt_state == VFP) && (nxt_h == H_LAST) && (nxt_line == VFP_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            cam_vsync  <= nxt_vsync;
            cam_href   <= nxt_href;
            cam_data   <= nxt_data;
            frame_done <= nxt_done;
            if (nxt_done)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Scoreboard bench for dvp_pattern_tx with a small frame geometry (L=40, 280-clock frames).
// Honours DVP_TX_FRAME_STAMP_EN when defined for the build.
module tb_dvp_pattern_tx;

    localparam int HP = 16;
    localparam int VP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] done_q[$];
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    always #5 clk = ~clk;

    dvp_pattern_tx #(
        .H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(8),
        .VSYNC_LINES(1), .V_BP(1), .V_FP(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pattern_sel(pattern_sel), .solid_color(solid_color),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_pixel(input int pat, input logic [15:0] solid,
                                              input int x, input int y);
        logic [7:0] xb;
        logic [7:0] yb;
        xb = 8'(x);
        yb = 8'(y);
        case (pat)
            0:       return bars[x / (HP / 8)];
            1:       return {xb[7:3], xb[7:2], xb[7:3]};
            2:       return (xb[5] ^ yb[5]) ? 16'hFFFF : 16'h0000;
            default: return solid;
        endcase
    endfunction

    task automatic push_frame(input int pat, input logic [15:0] solid, input logic [15:0] stamp);
        logic [15:0] p;
        logic use_stamp;
`ifdef DVP_TX_FRAME_STAMP_EN
        use_stamp = 1'b1;
`else
        use_stamp = 1'b0;
`endif
        for (int y = 0; y < VP; y++) begin
            for (int x = 0; x < HP; x++) begin
                p = exp_pixel(pat, solid, x, y);
                if (use_stamp && x == 0 && y == 0)
                    p = stamp;
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_vsync"}, 32'(cam_vsync), 0);
        check({name, "_href"},  32'(cam_href), 0);
        check({name, "_data"},  32'(cam_data), 0);
        check({name, "_done"},  32'(frame_done), 0);
        check({name, "_cnt"},   32'(frame_cnt), 0);
    endtask

    // Monitor: pops expected bytes while href is high, frame counts on frame_done.
    always @(negedge clk) begin
        if (!rst) begin
            if (cam_href) begin
                if (exp_q.size() == 0)
                    check("byte_unexpected", 32'(cam_data), 32'hFFFF_FFFF);
                else
                    check("byte", 32'(cam_data), 32'(exp_q.pop_front()));
            end else begin
                check("data_idle", 32'(cam_data), 0);
            end
            check("href_in_vsync", 32'(cam_href & cam_vsync), 0);
            if (frame_done) begin
                if (done_q.size() == 0)
                    check("done_unexpected", 32'(frame_cnt), 32'hFFFF_FFFF);
                else
                    check("done_cnt", 32'(frame_cnt), 32'(done_q.pop_front()));
            end
        end
    end

    // Entered on frame clock 1 (first vsync clock); runs through clock 280.
    task automatic track_frame(input int action, input logic [15:0] exp_cnt);
        int href_hi = 0;
        int pulses  = 0;
        logic prev  = 1'b0;
        for (int n = 1; n <= 280; n++) begin
            if (n > 1) @(negedge clk);
            if (cam_href) href_hi++;
            if (cam_href && !prev) pulses++;
            prev = cam_href;
            if (n == 40)  check("vsync_last", 32'(cam_vsync), 1);
            if (n == 41)  check("vsync_fall", 32'(cam_vsync), 0);
            if (n == 80)  check("href_before", 32'(cam_href), 0);
            if (n == 81)  check("href_first", 32'(cam_href), 1);
            if (n == 279) begin
                check("done_early", 32'(frame_done), 0);
                check("cnt_before", 32'(frame_cnt), 32'(exp_cnt - 16'd1));
            end
            if (n == 280) begin
                check("done_pulse", 32'(frame_done), 1);
                check("cnt_after", 32'(frame_cnt), 32'(exp_cnt));
            end
            if (n == 100) begin
                case (action)
                    1: begin
                        pattern_sel = 2'd2;
                        push_frame(2, solid_color, exp_cnt);
                        done_q.push_back(exp_cnt + 16'd1);
                    end
                    2: begin
                        pattern_sel = 2'd3;
                        solid_color = 16'hA5C3;
                        push_frame(3, 16'hA5C3, exp_cnt);
                        done_q.push_back(exp_cnt + 16'd1);
                    end
                    3: enable = 1'b0;
                    default: ;
                endcase
            end
        end
        check("href_clocks", 32'(href_hi), 128);
        check("href_pulses", 32'(pulses), 4);
    endtask

    task automatic wait_vsync(input string name);
        int waited = 0;
        logic found = 1'b0;
        while (!found && waited < 1000) begin
            @(negedge clk);
            waited++;
            if (cam_vsync) found = 1'b1;
        end
        check(name, 32'(waited), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        enable      = 1'b1;
        pattern_sel = 2'd0;
        solid_color = 16'h1234;
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Frame A: colour bars; pattern 2 selected mid-frame for frame B.
        push_frame(0, 16'h1234, 16'd0);
        done_q.push_back(16'd1);
        rst = 1'b0;
        #1 check("vsync_pre", 32'(cam_vsync), 0);
        @(negedge clk);
        check("vsync_rise", 32'(cam_vsync), 1);
        track_frame(1, 16'd1);

        @(negedge clk);
        check("no_gap_ab", 32'(cam_vsync), 1);
        track_frame(2, 16'd2);

        @(negedge clk);
        check("no_gap_bc", 32'(cam_vsync), 1);
        track_frame(3, 16'd3);

        @(negedge clk);
        check("idle_vsync", 32'(cam_vsync), 0);
        repeat (30) @(negedge clk);
        check("idle_vsync_hold", 32'(cam_vsync), 0);
        check("idle_href", 32'(cam_href), 0);
        check("idle_cnt", 32'(frame_cnt), 3);

        // Frame D: grey ramp, interrupted by reset in the middle of a line.
        pattern_sel = 2'd1;
        push_frame(1, solid_color, 16'd3);
        done_q.push_back(16'd4);
        enable = 1'b1;
        wait_vsync("vsync_from_idle");
        repeat (85) @(negedge clk);
        check("href_mid", 32'(cam_href), 1);
        rst = 1'b1;
        #1 check_zero("reset_mid_href");
        exp_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);

        // Frame E: clean grey-ramp frame after reset.
        push_frame(1, solid_color, 16'd0);
        done_q.push_back(16'd1);
        rst = 1'b0;
        #1 check("vsync_pre_e", 32'(cam_vsync), 0);
        @(negedge clk);
        check("vsync_rise_e", 32'(cam_vsync), 1);
        track_frame(3, 16'd1);
        @(negedge clk);
        check("idle_end", 32'(cam_vsync), 0);
        repeat (5) @(negedge clk);

        check("bytes_left", 32'(exp_q.size()), 0);
        check("done_left", 32'(done_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
